// File: rtl/alu4_pkg.sv
// Shared definitions for the two-port ALU arbiter: op codes, flag bit positions
// and the arbiter state/debug types.
package alu4_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_SEQ = 3'b111;

  localparam int FLG_ZERO  = 3;
  localparam int FLG_OVF   = 2;
  localparam int FLG_CARRY = 1;
  localparam int FLG_SIZE  = 0;

  typedef enum logic {
    ARB_RR   = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  // Arbiter state exported for checkers: FSM state, lock owner, priority pointer.
  typedef struct packed {
    arb_state_e state;
    logic       owner;
    logic       ptr;
  } arb_dbg_t;

endpackage

// File: rtl/alu4_core.sv
// Combinational 4-bit ALU. Subtracting ops (SUB/SLT/SEQ) share the adder by
// feeding ~b with a forced carry-in of 1.
module alu4_core
  import alu4_pkg::*;
(
  input  logic [2:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] result,
  output logic [3:0] flags
);

  logic       sub;
  logic [3:0] b_eff;
  logic       c_eff;
  logic [4:0] sum;
  logic       ovf;

  always_comb begin
    sub    = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SEQ);
    b_eff  = sub ? ~b : b;
    c_eff  = sub ? 1'b1 : cin;
    sum    = {1'b0, a} + {1'b0, b_eff} + {4'b0000, c_eff};
    ovf    = (a[3] == b_eff[3]) && (sum[3] != a[3]);
    result = sum[3:0];
    flags  = '0;
    case (op)
      OP_ADD, OP_SUB: begin
        flags[FLG_OVF]   = ovf;
        flags[FLG_CARRY] = sum[4];
      end
      OP_SLT: begin
        flags[FLG_OVF]   = ovf;
        flags[FLG_CARRY] = sum[4];
        flags[FLG_SIZE]  = sum[3] ^ ovf;
      end
      OP_SEQ: begin
        flags[FLG_OVF]   = ovf;
        flags[FLG_CARRY] = sum[4];
        flags[FLG_SIZE]  = (a == b);
      end
      OP_NOT:  result = ~a;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = sum[3:0];
    endcase
    flags[FLG_ZERO] = (result == 4'h0);
  end

endmodule

// File: rtl/alu4_arb.sv
// Round-robin arbiter sharing one alu4_core between two requesters, with a
// one-entry registered response slot per requester and an optional ownership lock.
module alu4_arb
  import alu4_pkg::*;
#(
  parameter int RR_INIT = 0
)(
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid_i,
  output logic [1:0]      req_ready_o,
  input  logic [1:0][2:0] req_op_i,
  input  logic [1:0][3:0] req_a_i,
  input  logic [1:0][3:0] req_b_i,
  input  logic [1:0]      req_cin_i,
  input  logic [1:0]      req_lock_i,
  output logic [1:0]      rsp_valid_o,
  input  logic [1:0]      rsp_ready_i,
  output logic [1:0][3:0] rsp_result_o,
  output logic [1:0][3:0] rsp_flags_o,
  output arb_dbg_t        dbg_o
);

  localparam logic PTR_RST = (RR_INIT != 0);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       ptr_q, ptr_d;
  logic [1:0] elig;
  logic [1:0] grant;
  logic       sel;

  logic [2:0] alu_op;
  logic [3:0] alu_a, alu_b, alu_result, alu_flags;
  logic       alu_cin;

  // Handshake: a request transfers when valid & ready in the same cycle; ready
  // is the one-hot grant and may depend on valid. A response is consumed when
  // rsp_valid & rsp_ready; a consumer freeing the slot lets a new grant land in
  // that same cycle.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    grant   = '0;
    elig    = req_valid_i & (~rsp_valid_o | rsp_ready_i);
    if (!rst) begin
      if (state_q == ARB_LOCK) begin
        grant[owner_q] = elig[owner_q];
      end else if (elig == 2'b11) begin
        grant[ptr_q] = 1'b1;
      end else begin
        grant = elig;
      end
    end
    sel = grant[1];
    if (grant != 2'b00) begin
      if (req_lock_i[sel]) begin
        state_d = ARB_LOCK;
        owner_d = sel;
      end else begin
        state_d = ARB_RR;
        ptr_d   = ~sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_RR;
      owner_q <= 1'b0;
      ptr_q   <= PTR_RST;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign req_ready_o = grant;

  assign alu_op  = req_op_i[sel];
  assign alu_a   = req_a_i[sel];
  assign alu_b   = req_b_i[sel];
  assign alu_cin = req_cin_i[sel];

  alu4_core u_core (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .cin    (alu_cin),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // A reload wins over a drain so back-to-back operations keep valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_o  <= '0;
      rsp_result_o <= '0;
      rsp_flags_o  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (grant[i]) begin
          rsp_valid_o[i]  <= 1'b1;
          rsp_result_o[i] <= alu_result;
          rsp_flags_o[i]  <= alu_flags;
        end else if (rsp_ready_i[i]) begin
          rsp_valid_o[i] <= 1'b0;
        end
      end
    end
  end

  assign dbg_o.state = state_q;
  assign dbg_o.owner = owner_q;
  assign dbg_o.ptr   = ptr_q;

endmodule

// File: tb/tb_alu4_arb.sv
// Self-checking bench for alu4_arb: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_alu4_arb;
  import alu4_pkg::*;

  localparam int TB_RR_INIT = 0;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [1:0][2:0] req_op = '0;
  logic [1:0][3:0] req_a = '0;
  logic [1:0][3:0] req_b = '0;
  logic [1:0]      req_cin = '0;
  logic [1:0]      req_lock = '0;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready = 2'b11;
  logic [1:0][3:0] rsp_result;
  logic [1:0][3:0] rsp_flags;
  arb_dbg_t        dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: expected {flags, result} per port, front = what the slot must show.
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  bit         m_locked = 1'b0;
  int         m_owner  = 0;
  int         m_ptr    = TB_RR_INIT;

  // Clock / reset
  always #5 clk = ~clk;

  alu4_arb #(.RR_INIT(TB_RR_INIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_i     (req_op),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_cin_i    (req_cin),
    .req_lock_i   (req_lock),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_result_o (rsp_result),
    .rsp_flags_o  (rsp_flags),
    .dbg_o        (dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from plain integer arithmetic; returns {zero, ovf, carry, size, result}.
  function automatic logic [7:0] model_alu(input logic [2:0] op, input logic [3:0] a,
                                           input logic [3:0] b, input logic cin);
    int ua, ub, sa, sb, s, d;
    logic [3:0] r;
    logic v, c, sz;
    ua = int'(a);
    ub = int'(b);
    sa = a[3] ? ua - 16 : ua;
    sb = b[3] ? ub - 16 : ub;
    r = '0; v = 1'b0; c = 1'b0; sz = 1'b0;
    case (op)
      OP_ADD: begin
        s = ua + ub + int'(cin);
        r = 4'(s);
        c = (s > 15);
        d = sa + sb + int'(cin);
        v = (d > 7) || (d < -8);
      end
      OP_SUB, OP_SLT, OP_SEQ: begin
        r = 4'(ua - ub);
        c = (ua >= ub);
        d = sa - sb;
        v = (d > 7) || (d < -8);
        if (op == OP_SLT) sz = (sa < sb);
        if (op == OP_SEQ) sz = (ua == ub);
      end
      OP_NOT:  r = ~a;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      default: r = a ^ b;
    endcase
    return {(r == 4'h0), v, c, sz, r};
  endfunction

  // Compare process: outputs vs model every cycle, then advance the model.
  always @(negedge clk) begin : cmp
    logic [1:0] elig;
    logic [1:0] exp_gnt;
    int g;
    check("rsp_valid0", rsp_valid[0], exp_q0.size() != 0);
    check("rsp_valid1", rsp_valid[1], exp_q1.size() != 0);
    if (exp_q0.size() != 0) check("rsp0 data", {rsp_flags[0], rsp_result[0]}, exp_q0[0]);
    if (exp_q1.size() != 0) check("rsp1 data", {rsp_flags[1], rsp_result[1]}, exp_q1[0]);
    exp_gnt = 2'b00;
    if (!rst) begin
      elig[0] = req_valid[0] && (exp_q0.size() == 0 || rsp_ready[0]);
      elig[1] = req_valid[1] && (exp_q1.size() == 0 || rsp_ready[1]);
      if (m_locked) elig[1 - m_owner] = 1'b0;
      if (elig == 2'b11) exp_gnt[m_ptr] = 1'b1;
      else exp_gnt = elig;
    end
    check("req_ready", req_ready, exp_gnt);
    check("ready not 11", req_ready == 2'b11, 1'b0);
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
      m_locked = 1'b0;
      m_owner  = 0;
      m_ptr    = TB_RR_INIT;
    end else begin
      if (exp_q0.size() != 0 && rsp_ready[0]) void'(exp_q0.pop_front());
      if (exp_q1.size() != 0 && rsp_ready[1]) void'(exp_q1.pop_front());
      if (exp_gnt[0]) exp_q0.push_back(model_alu(req_op[0], req_a[0], req_b[0], req_cin[0]));
      if (exp_gnt[1]) exp_q1.push_back(model_alu(req_op[1], req_a[1], req_b[1], req_cin[1]));
      if (exp_gnt != 2'b00) begin
        g = exp_gnt[1] ? 1 : 0;
        if (req_lock[g]) begin
          m_locked = 1'b1;
          m_owner  = g;
        end else begin
          m_locked = 1'b0;
          m_ptr    = 1 - g;
        end
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [2:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic cin, input logic lk);
    req_valid[i] = v;
    req_op[i]    = op;
    req_a[i]     = a;
    req_b[i]     = b;
    req_cin[i]   = cin;
    req_lock[i]  = lk;
  endtask

  task automatic run_op(input string nm, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic cin, input logic [3:0] er,
                        input logic [3:0] ef);
    drive(0, 1'b1, op, a, b, cin, 1'b0);
    @(negedge clk);
    check({nm, " ready"}, req_ready, 2'b01);
    step();
    drive(0, 1'b0, op, a, b, cin, 1'b0);
    @(negedge clk);
    check({nm, " result"}, rsp_result[0], er);
    check({nm, " flags"}, rsp_flags[0], ef);
    step();
  endtask

  initial begin
    check("model add ovf", model_alu(OP_ADD, 4'h7, 4'h1, 1'b0), 8'h48);
    check("model sub zero", model_alu(OP_SUB, 4'h3, 4'h3, 1'b0), 8'hA0);
    check("model slt", model_alu(OP_SLT, 4'h8, 4'h1, 1'b0), 8'h77);

    // Reset with both requesters already valid
    drive(0, 1'b1, OP_ADD, 4'h3, 4'h4, 1'b0, 1'b0);
    drive(1, 1'b1, OP_XOR, 4'hA, 4'h5, 1'b0, 1'b0);
    @(negedge clk);
    check("rst ready", req_ready, 2'b00);
    check("rst valid", rsp_valid, 2'b00);
    check("rst result", rsp_result, 8'h00);
    check("rst flags", rsp_flags, 8'h00);
    check("rst state", dbg.state, ARB_RR);
    step();
    rst = 1'b0;

    // Contention after reset: port 0 first, port 1 next
    @(negedge clk);
    check("first grant", req_ready, 2'b01);
    step();
    drive(0, 1'b0, OP_ADD, 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("add3+4 result", rsp_result[0], 4'h7);
    check("add3+4 flags", rsp_flags[0], 4'h0);
    check("second grant", req_ready, 2'b10);
    step();
    drive(1, 1'b0, OP_XOR, 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("xor result", rsp_result[1], 4'hF);
    check("xor flags", rsp_flags[1], 4'h0);
    check("slot0 drained", rsp_valid, 2'b10);
    step();

    // Op table
    run_op("add7+1", OP_ADD, 4'h7, 4'h1, 1'b0, 4'h8, 4'b0100);
    run_op("sub3-3", OP_SUB, 4'h3, 4'h3, 1'b0, 4'h0, 4'b1010);
    run_op("slt8,1", OP_SLT, 4'h8, 4'h1, 1'b0, 4'h7, 4'b0111);
    run_op("seq5,5", OP_SEQ, 4'h5, 4'h5, 1'b0, 4'h0, 4'b1011);
    run_op("not5",   OP_NOT, 4'h5, 4'h0, 1'b0, 4'hA, 4'b0000);
    run_op("andCA",  OP_AND, 4'hC, 4'hA, 1'b0, 4'h8, 4'b0000);
    run_op("or00",   OP_OR,  4'h0, 4'h0, 1'b0, 4'h0, 4'b1000);

    // Lock on port 0 while port 1 waits
    drive(1, 1'b1, OP_OR, 4'h1, 4'h2, 1'b0, 1'b0);
    @(negedge clk);
    check("pre-lock p1 grant", req_ready, 2'b10);
    step();
    drive(0, 1'b1, OP_ADD, 4'hF, 4'h1, 1'b0, 1'b1);
    @(negedge clk);
    check("or result", rsp_result[1], 4'h3);
    check("lock grant", req_ready, 2'b01);
    step();
    drive(0, 1'b0, OP_ADD, 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("lock add result", rsp_result[0], 4'h0);
    check("lock add flags", rsp_flags[0], 4'b1010);
    check("locked out p1", req_ready, 2'b00);
    step();
    @(negedge clk);
    check("lock idle ready", req_ready, 2'b00);
    check("lock state", dbg.state, ARB_LOCK);
    step();
    drive(0, 1'b1, OP_ADD, 4'h0, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("unlock grant", req_ready, 2'b01);
    step();
    drive(0, 1'b0, OP_ADD, 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("unlock result", rsp_result[0], 4'h1);
    check("unlock flags", rsp_flags[0], 4'h0);
    check("p1 after unlock", req_ready, 2'b10);
    step();
    drive(1, 1'b0, OP_OR, 4'h0, 4'h0, 1'b0, 1'b0);
    step();

    // Backpressure on port 0, then drain and reload in the same cycle
    rsp_ready = 2'b10;
    drive(0, 1'b1, OP_ADD, 4'h1, 4'h1, 1'b0, 1'b0);
    @(negedge clk);
    check("bp first grant", req_ready, 2'b01);
    step();
    drive(0, 1'b1, OP_XOR, 4'h3, 4'h5, 1'b0, 1'b0);
    @(negedge clk);
    check("bp blocked", req_ready, 2'b00);
    check("bp hold", rsp_result[0], 4'h2);
    step();
    @(negedge clk);
    check("bp still blocked", req_ready, 2'b00);
    check("bp still hold", rsp_result[0], 4'h2);
    check("bp valid", rsp_valid[0], 1'b1);
    step();
    rsp_ready = 2'b11;
    @(negedge clk);
    check("drain+grant", req_ready, 2'b01);
    step();
    drive(0, 1'b0, OP_XOR, 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("reload valid", rsp_valid[0], 1'b1);
    check("reload result", rsp_result[0], 4'h6);
    step();

    // Reset in LOCK(1) with both slots full
    rsp_ready = 2'b00;
    drive(0, 1'b1, OP_AND, 4'hF, 4'h3, 1'b0, 1'b0);
    @(negedge clk);
    check("fill p0", req_ready, 2'b01);
    step();
    drive(0, 1'b0, OP_AND, 4'h0, 4'h0, 1'b0, 1'b0);
    drive(1, 1'b1, OP_ADD, 4'h2, 4'h2, 1'b0, 1'b1);
    @(negedge clk);
    check("fill p1 lock", req_ready, 2'b10);
    step();
    drive(1, 1'b0, OP_ADD, 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("both full", rsp_valid, 2'b11);
    check("lock1 state", dbg.state, ARB_LOCK);
    check("lock1 owner", dbg.owner, 1'b1);
    step();
    rst = 1'b1;
    drive(0, 1'b1, OP_ADD, 4'h1, 4'h1, 1'b0, 1'b0);
    drive(1, 1'b1, OP_ADD, 4'h2, 4'h2, 1'b0, 1'b0);
    @(negedge clk);
    check("rst lock ready", req_ready, 2'b00);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post rst valid", rsp_valid, 2'b00);
    check("post rst state", dbg.state, ARB_RR);
    check("post rst grant", req_ready, 2'b01);
    step();
    rsp_ready = 2'b11;
    drive(0, 1'b0, OP_ADD, 4'h0, 4'h0, 1'b0, 1'b0);
    drive(1, 1'b0, OP_ADD, 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("post rst result", rsp_result[0], 4'h2);
    step();

    // Random back-to-back traffic, checked by the compare process
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        drive(i, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
        rsp_ready[i] = $urandom_range(0, 3) != 0;
      end
      step();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (3) step();
    @(negedge clk);
    check("final drained", rsp_valid, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu4_arb.md
# alu4_arb

Two-port round-robin arbiter and result buffer that shares a single combinational 4-bit ALU between two requesters in the npc datapath. Each requester issues one operation at a time through a valid/ready handshake and receives a registered result with flags one cycle later. A lock mechanism lets one requester hold the ALU across consecutive operations, for example 8-bit carry chains.

## Interface
- `RR_INIT`, default 0: requester given priority after reset (0 or 1).
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid_i[1:0]` in 2: per-requester operation request.
- `req_ready_o[1:0]` out 2: grant; a transfer occurs when valid and ready are both high.
- `req_op_i[1:0][2:0]` in 6: op code per requester.
- `req_a_i[1:0][3:0]`, `req_b_i[1:0][3:0]` in 8 each: operands.
- `req_cin_i[1:0]` in 2: carry-in, used by ADD only.
- `req_lock_i[1:0]` in 2: keep ownership after this operation.
- `rsp_valid_o[1:0]` out 2: response slot full.
- `rsp_ready_i[1:0]` in 2: consumer accepts the response.
- `rsp_result_o[1:0][3:0]` out 8: registered ALU result.
- `rsp_flags_o[1:0][3:0]` out 8: `{zero, overflow, carry, size}`.

## Operation
- Op codes and results:
  - 000 ADD: `{carry, r} = a + b + cin`.
  - 001 SUB: `{carry, r} = a + ~b + 1`; carry=1 means no borrow.
  - 010 NOT: `r = ~a`.
  - 011 AND, 100 OR, 101 XOR.
  - 110 SLT: SUB datapath; `size = signed(a) < signed(b)`, computed as `r[3] ^ overflow`.
  - 111 SEQ: SUB datapath; `size = (a == b)`.
- Flag rules:
  - `zero = (r == 0)` for all ops.
  - `overflow` is signed overflow for ADD, SUB, SLT and SEQ (for the subtracting ops, computed against `~b`).
  - `carry` and `overflow` are 0 for logic ops. `size` is 0 except for SLT and SEQ.
- Eligibility: requester i is eligible when `req_valid_i[i]` is high and either `rsp_valid_o[i]` is low or `rsp_ready_i[i]` is high in the same cycle.
- Arbitration states:
  - RR:
    - If both are eligible, grant the requester at the priority pointer; if one is eligible, grant it.
    - After a grant to i without lock, the pointer moves to 1-i.
    - A grant to i with lock set moves to LOCK(i).
  - LOCK(i):
    - Only requester i is eligible; the other sees ready=0.
    - A grant to i without lock returns to RR with the pointer at 1-i.
    - LOCK(i) persists indefinitely while requester i is idle.
- `req_ready_o` depends combinationally on `req_valid_i`, the state and the response slot. At most one bit is high per cycle.
- On a grant to i, the ALU output loads into requester i's slot and `rsp_valid_o[i]` sets.
- A slot clears on `rsp_valid & rsp_ready` unless it is reloaded in the same cycle; a reload takes precedence and valid stays high.
- Result and flags hold stable while `rsp_valid_o` is high and `rsp_ready_i` is low.

## Timing
- Latency: a request accepted in cycle N produces its response in cycle N+1.
- Throughput: one operation per cycle in aggregate. Each requester can sustain one operation per cycle when its consumer keeps `rsp_ready_i` high.
- Reset values:
  - `rsp_valid_o = 0`, `rsp_result_o = 0`, `rsp_flags_o = 0`.
  - State = RR, pointer = `RR_INIT`.
  - `req_ready_o = 0` whenever `rst` is high.
- Reset mid-lock or with full slots: everything returns to the reset values on the next edge, and pending responses are dropped.
- Invalid `RR_INIT` values (outside 0 and 1) are not supported.

## Structure
- Package `alu4_pkg` holds:
  - op code constants `OP_ADD` … `OP_SEQ`;
  - flag bit indices `FLG_ZERO=3`, `FLG_OVF=2`, `FLG_CARRY=1`, `FLG_SIZE=0`;
  - an arbiter state enum `{ARB_RR, ARB_LOCK}` plus a separate owner bit.
- Sub-module `alu4_core` is purely combinational: op, a, b and cin in; result and the 4 flags out. It is instanced once, with its input mux driven by the grant.
- The top level contains the arbiter FSM, the priority pointer and the two response slots.

## Test plan
- Reset, then both requesters valid with ADD (3+4, cin=0) and XOR (0xA^0x5) → requester 0 granted first (`RR_INIT=0`); its response is 7 with flags 0000. Requester 1 is granted the next cycle; its response is 0xF with flags 0000.
- ADD 0x7+0x1 → result 0x8 with overflow=1. SUB 0x3−0x3 → result 0 with zero=1 and carry=1. SLT 0x8 vs 0x1 → size=1. SEQ 0x5 vs 0x5 → size=1 and zero=1.
- Requester 0 issues with lock=1 (ADD 0xF+0x1, producing carry=1), then with lock=0 (ADD 0x0+0x0, cin=1); requester 1 holds valid throughout. → Requester 1 stays ready=0 until the lock=0 grant; that grant's response is 0x1, and requester 1 is granted the cycle after.
- Hold `rsp_ready_i[0]=0` with `rsp_valid_o[0]=1`, then a new request on port 0 → `req_ready_o[0]=0` and the slot holds its value. Raise ready → the slot drains and the new grant occurs in the same cycle; `rsp_valid_o[0]` stays high with the new result.
- Assert `rst` while in LOCK(1) with both slots full → next cycle `rsp_valid_o=00`, state is RR, and the first contended grant goes to `RR_INIT`.
- Random back-to-back traffic → compare against a reference model: no lost or duplicated responses, and `req_ready_o` is never 11.
